// File: rtl/multiport_reg_file.sv
// Parametrised register file: NUM_RD combinational read ports, two prioritised write ports, sequenced clear.
// Optional write-to-read forwarding is enabled by defining MULTIPORT_REG_FILE_BYPASS_EN.
module multiport_reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     clr_req,
    output logic                     ready,
    output logic                     wr_conflict
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic run_ok;
    logic same_addr;
    logic wr0_go;
    logic wr1_go;
    logic wr0_keep;

    // A write only lands in RUN, when no clear is being requested, and never to a hardwired-zero entry.
    assign run_ok    = (state == ST_RUN) && !clr_req;
    assign same_addr = (wr0_addr == wr1_addr);
    assign wr0_go    = run_ok && wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
    assign wr1_go    = run_ok && wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));
    assign wr0_keep  = wr0_go && !(wr1_go && same_addr);

    assign ready = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_CLEAR;
            clr_ptr     <= '0;
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= wr0_go && wr1_go && same_addr;
            if (state == ST_CLEAR) begin
                if (clr_req) begin
                    clr_ptr <= '0;
                end else begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (&clr_ptr) begin
                        state <= ST_RUN;
                    end
                end
            end else if (clr_req) begin
                state   <= ST_CLEAR;
                clr_ptr <= '0;
            end
        end
    end

    // The array has no reset so it can map onto plain RAM; zeroing is done one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_CLEAR) begin
                mem[clr_ptr] <= '0;
            end else begin
                if (wr0_keep) begin
                    mem[wr0_addr] <= wr0_data;
                end
                if (wr1_go) begin
                    mem[wr1_addr] <= wr1_data;
                end
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] rd_idx;
            logic [DATA_W-1:0] rd_val;

            assign rd_idx = rd_addr[k*ADDR_W +: ADDR_W];

            always_comb begin
                rd_val = mem[rd_idx];
`ifdef MULTIPORT_REG_FILE_BYPASS_EN
                if (wr0_keep && (wr0_addr == rd_idx)) begin
                    rd_val = wr0_data;
                end
                if (wr1_go && (wr1_addr == rd_idx)) begin
                    rd_val = wr1_data;
                end
`endif
                if ((state != ST_RUN) || ((ZERO_REG != 0) && (rd_idx == '0))) begin
                    rd_val = '0;
                end
            end

            assign rd_data[k*DATA_W +: DATA_W] = rd_val;
        end
    endgenerate

endmodule

// File: doc/multiport_reg_file.md
# multiport_reg_file

Parametrised general-purpose register file for the core datapath, succeeding the fixed 32x32 two-read/one-write file. It provides configurable width and depth, N combinational read ports and two synchronous write ports with fixed priority. It also has an optional hardwired-zero entry and a sequenced clear engine, so the array maps to RAM primitives that cannot be reset in one cycle. It sits between decode (read addresses) and writeback (ALU port 0, load/second-result port 1).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 entry 0 reads as zero and ignores writes
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- wr0_en / wr0_addr / wr0_data  in  1 / ADDR_W / DATA_W  write port 0
- wr1_en / wr1_addr / wr1_data  in  1 / ADDR_W / DATA_W  write port 1 (higher priority)
- clr_req  in  1  single-cycle request to re-run the clear sequence
- ready  out  1  high when the array is valid and accepting writes
- wr_conflict  out  1  registered one-cycle pulse: both ports wrote the same address last cycle

## Operation
- FSM states: CLEAR, RUN. An internal clr_ptr counter is ADDR_W bits wide.
- Reset (rst_n low at an edge):
  - State goes to CLEAR and clr_ptr goes to 0.
  - ready = 0 and wr_conflict = 0.
  - Array contents are not touched in the reset cycle itself.
- CLEAR, each edge:
  - Writes mem[clr_ptr] <= 0 and increments clr_ptr.
  - When clr_ptr == DEPTH-1 the state moves to RUN on that edge. clr_ptr then wraps to 0.
  - wr0/wr1 are ignored and rd_data is forced to all-zero.
- RUN:
  - Reads are combinational: rd_data[k] = mem[rd_addr[k]].
  - If ZERO_REG=1 and rd_addr[k]==0, rd_data[k] = 0 regardless of array content.
  - A write is performed for port p when wrp_en=1 and not (ZERO_REG=1 and wrp_addr==0).
  - Both ports may write different addresses in the same cycle.
  - If both write the same address, wr1 wins and wr0 is dropped. Then wr_conflict = 1 for exactly the next cycle.
  - A dropped zero-register write does not count as a conflict.
- clr_req:
  - Sampled only when rst_n is high.
  - In RUN it moves the state to CLEAR with clr_ptr = 0. Any writes in that same cycle are dropped.
  - In CLEAR it restarts clr_ptr at 0.
- rst_n has priority over clr_req. Reset asserted mid-clear restarts the sequence from entry 0.

## Timing
- Read latency is 0 cycles (combinational from rd_addr and array state).
- Write latency: data written at edge N is visible on rd_data after edge N. Without bypass it is not visible in the same cycle.
- Clear duration: ready rises after the DEPTH-th rising edge following the last edge with rst_n low or clr_req high (32 edges at default).
- ready falls on the edge that samples rst_n low or clr_req high in RUN.
- wr_conflict is registered: high during cycle N+1 for a conflict at edge N. It is 0 in CLEAR.

## Configuration
- Macro: MULTIPORT_REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding in RUN.
  - If a read address matches an enabled, non-dropped write address in the same cycle, rd_data returns that write data (wr1 over wr0).
  - ZERO_REG masking still applies.
- Undefined: rd_data returns the pre-write array content. No forwarding logic is generated.

## Test plan
- Release rst_n after 3 low cycles:
  - ready = 0 for 32 edges, then 1.
  - All 32 entries read 0.
  - A write of 0xDEADBEEF to entry 5 during CLEAR is lost.
- In RUN, wr0 writes 0x11111111 to entry 3 and wr1 writes 0x22222222 to entry 7 in the same cycle -> next cycle rd_addr {3,7} returns {0x11111111, 0x22222222}; wr_conflict = 0.
- wr0 writes 0xAAAA0000 and wr1 writes 0x0000BBBB, both to entry 9 -> entry 9 reads 0x0000BBBB; wr_conflict = 1 for one cycle only.
- With ZERO_REG=1, write 0xFFFFFFFF to entry 0 -> reads 0; wr_conflict stays 0 even when both ports target entry 0.
- Pulse clr_req after filling entries 1..31, then pulse rst_n low at clear cycle 10:
  - ready stays low.
  - Clear restarts.
  - ready rises 32 edges after reset release, and all entries read 0.
- Bypass: write 0x12345678 to entry 4 while reading entry 4 -> same-cycle rd_data = 0x12345678 with MULTIPORT_REG_FILE_BYPASS_EN defined, and the old value without it.
